// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for an IF -> ID/EX -> WB pipeline: operand
// forwarding selects, WB-stage register tracking, load-latency stall and redirect kill.
module pipeline_hazard_ctrl #(
    parameter int LOAD_LAT     = 0,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       id_op1_pc,
    input  logic       id_op2_imm,
    input  logic [4:0] id_rd,
    input  logic       id_reg_we,
    input  logic       id_is_load,
    input  logic [1:0] id_wb_sel,
    input  logic       redirect,
    output logic [1:0] reg1_judge,
    output logic [1:0] reg2_judge,
    output logic [1:0] wb_sel,
    output logic [4:0] wb_rd,
    output logic       wb_we,
    output logic       stall,
    output logic       kill
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_FLUSH     = 2'd2
    } state_t;

    localparam logic [2:0] LAT_INIT   = 3'(LOAD_LAT);
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

    state_t     state_q, state_d;
    logic [2:0] lcnt_q, lcnt_d;
    logic [1:0] fcnt_q, fcnt_d;
    logic [1:0] wb_sel_q, wb_sel_d;
    logic [4:0] wb_rd_q, wb_rd_d;
    logic       wb_we_q, wb_we_d;
    logic       wb_load_q, wb_load_d;

    logic       lcnt_busy_s;
    logic       stall_s;
    logic       kill_s;
    logic       issue_s;
    logic       wb_we_s;
    logic       fwd1_s;
    logic       fwd2_s;
    logic [1:0] reg1_judge_s;
    logic [1:0] reg2_judge_s;

    // Hazard decode, issue qualification and operand-select priority.
    always_comb begin
        lcnt_busy_s  = (state_q == ST_LOAD_WAIT) && (lcnt_q != 3'd0);
        stall_s      = lcnt_busy_s & wb_load_q;
        kill_s       = (state_q == ST_FLUSH);
        issue_s      = id_valid & ~stall_s & ~kill_s;
        wb_we_s      = wb_we_q & ~lcnt_busy_s;
        fwd1_s       = id_use_rs1 & wb_we_s & (wb_rd_q == id_rs1);
        fwd2_s       = id_use_rs2 & wb_we_s & (wb_rd_q == id_rs2);
        reg1_judge_s = 2'b00;
        reg2_judge_s = 2'b00;
        if (id_valid && !kill_s) begin
            if (id_op1_pc) begin
                reg1_judge_s = 2'b10;
            end else if (fwd1_s) begin
                reg1_judge_s = 2'b01;
            end else begin
                reg1_judge_s = 2'b00;
            end
            if (id_op2_imm) begin
                reg2_judge_s = 2'b10;
            end else if (fwd2_s) begin
                reg2_judge_s = 2'b01;
            end else begin
                reg2_judge_s = 2'b00;
            end
        end else begin
            reg1_judge_s = 2'b00;
            reg2_judge_s = 2'b00;
        end
    end

    // Next-state and counter logic for RUN / LOAD_WAIT / FLUSH.
    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_RUN, ST_LOAD_WAIT: begin
                if (lcnt_busy_s) begin
                    lcnt_d = lcnt_q - 3'd1;
                end else if (issue_s && redirect) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FLUSH_INIT;
                end else if (issue_s && id_is_load && (LAT_INIT != 3'd0)) begin
                    state_d = ST_LOAD_WAIT;
                    lcnt_d  = LAT_INIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Leaving on fcnt==1 makes kill last exactly FLUSH_CYCLES cycles.
                if (fcnt_q <= 2'd1) begin
                    state_d = ST_RUN;
                    fcnt_d  = 2'd0;
                end else begin
                    fcnt_d = fcnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                lcnt_d  = 3'd0;
                fcnt_d  = 2'd0;
            end
        endcase
    end

    // WB-stage register update: capture on issue, bubble when idle, hold while a load waits.
    always_comb begin
        wb_sel_d  = wb_sel_q;
        wb_rd_d   = wb_rd_q;
        wb_we_d   = wb_we_q;
        wb_load_d = wb_load_q;
        if (issue_s) begin
            wb_sel_d  = id_wb_sel;
            wb_rd_d   = id_rd;
            wb_we_d   = id_reg_we & (id_rd != 5'd0);
            wb_load_d = id_is_load;
        end else if (state_q != ST_LOAD_WAIT) begin
            wb_sel_d  = 2'b00;
            wb_rd_d   = 5'd0;
            wb_we_d   = 1'b0;
            wb_load_d = 1'b0;
        end else begin
            wb_sel_d  = wb_sel_q;
            wb_rd_d   = wb_rd_q;
            wb_we_d   = wb_we_q;
            wb_load_d = wb_load_q;
        end
    end

    // State, counter and WB registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            lcnt_q    <= 3'd0;
            fcnt_q    <= 2'd0;
            wb_sel_q  <= 2'b00;
            wb_rd_q   <= 5'd0;
            wb_we_q   <= 1'b0;
            wb_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lcnt_q    <= lcnt_d;
            fcnt_q    <= fcnt_d;
            wb_sel_q  <= wb_sel_d;
            wb_rd_q   <= wb_rd_d;
            wb_we_q   <= wb_we_d;
            wb_load_q <= wb_load_d;
        end
    end

    assign reg1_judge = reg1_judge_s;
    assign reg2_judge = reg2_judge_s;
    assign wb_sel     = wb_sel_q;
    assign wb_rd      = wb_rd_q;
    assign wb_we      = wb_we_s;
    assign stall      = stall_s;
    assign kill       = kill_s;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controller instances (LOAD_LAT=2/FLUSH=1 and LOAD_LAT=0/FLUSH=3)
// driven by directed vectors; a negedge monitor compares outputs against queued expectations.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       pc;
        logic       imm;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic [1:0] sel;
        logic       redir;
    } in_t;

    typedef struct packed {
        logic [1:0] r1;
        logic [1:0] r2;
        logic [1:0] sel;
        logic [4:0] rd;
        logic       we;
        logic       st;
        logic       k;
    } out_t;

    typedef struct {
        bit    dut;
        out_t  e;
        string nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    in_t  in_a, in_b;
    out_t act_a, act_b;

    logic [1:0] r1_a, r2_a, sel_a, r1_b, r2_b, sel_b;
    logic [4:0] rd_a, rd_b;
    logic       we_a, st_a, k_a, we_b, st_b, k_b;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_LAT(2), .FLUSH_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst_a), .id_valid(in_a.v), .id_rs1(in_a.rs1), .id_rs2(in_a.rs2),
        .id_use_rs1(in_a.u1), .id_use_rs2(in_a.u2), .id_op1_pc(in_a.pc), .id_op2_imm(in_a.imm),
        .id_rd(in_a.rd), .id_reg_we(in_a.we), .id_is_load(in_a.ld), .id_wb_sel(in_a.sel),
        .redirect(in_a.redir), .reg1_judge(r1_a), .reg2_judge(r2_a), .wb_sel(sel_a),
        .wb_rd(rd_a), .wb_we(we_a), .stall(st_a), .kill(k_a)
    );

    pipeline_hazard_ctrl #(.LOAD_LAT(0), .FLUSH_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst_b), .id_valid(in_b.v), .id_rs1(in_b.rs1), .id_rs2(in_b.rs2),
        .id_use_rs1(in_b.u1), .id_use_rs2(in_b.u2), .id_op1_pc(in_b.pc), .id_op2_imm(in_b.imm),
        .id_rd(in_b.rd), .id_reg_we(in_b.we), .id_is_load(in_b.ld), .id_wb_sel(in_b.sel),
        .redirect(in_b.redir), .reg1_judge(r1_b), .reg2_judge(r2_b), .wb_sel(sel_b),
        .wb_rd(rd_b), .wb_we(we_b), .stall(st_b), .kill(k_b)
    );

    assign act_a = {r1_a, r2_a, sel_a, rd_a, we_a, st_a, k_a};
    assign act_b = {r1_b, r2_b, sel_b, rd_b, we_b, st_b, k_b};

    function automatic in_t ins(int v, int rs1, int rs2, int u1, int u2, int pc, int imm,
                                int rd, int we, int ld, int sel, int redir);
        in_t i;
        i.v = 1'(v);     i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
        i.u1 = 1'(u1);   i.u2 = 1'(u2);   i.pc = 1'(pc);   i.imm = 1'(imm);
        i.rd = 5'(rd);   i.we = 1'(we);   i.ld = 1'(ld);   i.sel = 2'(sel);
        i.redir = 1'(redir);
        return i;
    endfunction

    function automatic out_t o(int r1, int r2, int sel, int rd, int we, int st, int k);
        out_t x;
        x.r1 = 2'(r1); x.r2 = 2'(r2); x.sel = 2'(sel); x.rd = 5'(rd);
        x.we = 1'(we); x.st = 1'(st); x.k = 1'(k);
        return x;
    endfunction

    // Drive one cycle of stimulus and queue its expected response.
    task automatic step(input bit d, input in_t i, input out_t e, input string nm);
        exp_t x;
        if (d) in_b = i;
        else   in_a = i;
        x.dut = d; x.e = e; x.nm = nm;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare whenever an expectation is pending for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            out_t act;
            x = exp_q.pop_front();
            act = x.dut ? act_b : act_a;
            tests_run++;
            if (act !== x.e) begin
                tests_failed++;
                $display("FAIL %s: got r1=%b r2=%b sel=%b rd=%0d we=%b stall=%b kill=%b, want r1=%b r2=%b sel=%b rd=%0d we=%b stall=%b kill=%b",
                         x.nm, act.r1, act.r2, act.sel, act.rd, act.we, act.st, act.k,
                         x.e.r1, x.e.r2, x.e.sel, x.e.rd, x.e.we, x.e.st, x.e.k);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t idle, add10, lw12, add6;
        idle = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        in_a = idle;
        in_b = idle;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;

        // Instance A: LOAD_LAT=2, FLUSH_CYCLES=1
        step(0, idle, o(0, 0, 0, 0, 0, 0, 0), "a_reset");
        step(0, ins(1, 1, 2, 1, 1, 0, 0, 5, 1, 0, 1, 0), o(0, 0, 0, 0, 0, 0, 0), "a_add_x5");
        step(0, ins(1, 5, 5, 1, 1, 0, 0, 6, 1, 0, 1, 0), o(1, 1, 1, 5, 1, 0, 0), "a_fwd_both");
        step(0, ins(1, 6, 6, 1, 1, 0, 0, 0, 1, 0, 1, 0), o(1, 1, 1, 6, 1, 0, 0), "a_fwd_x6");
        step(0, ins(1, 0, 0, 1, 1, 0, 0, 7, 1, 0, 1, 0), o(0, 0, 1, 0, 0, 0, 0), "a_x0_nofwd");
        step(0, ins(1, 7, 0, 1, 0, 1, 1, 8, 1, 0, 1, 0), o(2, 2, 1, 7, 1, 0, 0), "a_auipc");
        step(0, ins(1, 8, 0, 1, 0, 0, 1, 9, 1, 0, 1, 0), o(1, 2, 1, 8, 1, 0, 0), "a_addi");
        step(0, ins(1, 9, 0, 1, 0, 0, 1, 7, 1, 1, 2, 0), o(1, 2, 1, 9, 1, 0, 0), "a_lw_x7");
        step(0, ins(1, 7, 7, 1, 1, 0, 0, 10, 1, 0, 1, 1), o(0, 0, 2, 7, 0, 1, 0), "a_stall1_redir");
        add10 = ins(1, 7, 7, 1, 1, 0, 0, 10, 1, 0, 1, 0);
        step(0, add10, o(0, 0, 2, 7, 0, 1, 0), "a_stall2");
        step(0, add10, o(1, 1, 2, 7, 1, 0, 0), "a_load_done");
        step(0, ins(1, 10, 0, 1, 0, 0, 1, 11, 1, 1, 2, 0), o(1, 2, 1, 10, 1, 0, 0), "a_lw_x11");
        lw12 = ins(1, 11, 0, 1, 0, 0, 1, 12, 1, 1, 2, 0);
        step(0, lw12, o(0, 2, 2, 11, 0, 1, 0), "a_b2b_stall1");
        step(0, lw12, o(0, 2, 2, 11, 0, 1, 0), "a_b2b_stall2");
        step(0, lw12, o(1, 2, 2, 11, 1, 0, 0), "a_b2b_issue");
        step(0, idle, o(0, 0, 2, 12, 0, 1, 0), "a_reload1");
        step(0, idle, o(0, 0, 2, 12, 0, 1, 0), "a_reload2");
        step(0, idle, o(0, 0, 2, 12, 1, 0, 0), "a_reload_done");
        step(0, ins(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 3, 1), o(2, 2, 2, 12, 1, 0, 0), "a_jal");
        step(0, ins(1, 1, 0, 1, 0, 0, 0, 2, 1, 0, 1, 0), o(0, 0, 3, 1, 1, 0, 1), "a_kill");
        step(0, ins(1, 1, 0, 1, 0, 0, 0, 2, 1, 0, 1, 0), o(0, 0, 0, 0, 0, 0, 0), "a_resume");
        step(0, idle, o(0, 0, 1, 2, 1, 0, 0), "a_after_resume");
        step(0, ins(1, 0, 0, 0, 0, 0, 1, 3, 1, 1, 2, 0), o(0, 2, 0, 0, 0, 0, 0), "a_lw_x3");
        rst_a = 1'b1;
        step(0, idle, o(0, 0, 2, 3, 0, 1, 0), "a_mid_load_wait");
        step(0, idle, o(0, 0, 0, 0, 0, 0, 0), "a_in_reset");
        rst_a = 1'b0;
        step(0, idle, o(0, 0, 0, 0, 0, 0, 0), "a_after_reset");

        // Instance B: LOAD_LAT=0, FLUSH_CYCLES=3
        rst_a = 1'b1;
        rst_b = 1'b0;
        step(1, idle, o(0, 0, 0, 0, 0, 0, 0), "b_reset");
        step(1, ins(1, 0, 0, 0, 0, 0, 1, 4, 1, 1, 2, 0), o(0, 2, 0, 0, 0, 0, 0), "b_lw_x4");
        step(1, ins(1, 4, 0, 1, 0, 0, 0, 5, 1, 0, 1, 0), o(1, 0, 2, 4, 1, 0, 0), "b_lat0_fwd");
        step(1, ins(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 3, 1), o(2, 2, 1, 5, 1, 0, 0), "b_jal");
        add6 = ins(1, 1, 0, 1, 0, 0, 0, 6, 1, 0, 1, 0);
        step(1, add6, o(0, 0, 3, 1, 1, 0, 1), "b_kill1");
        step(1, add6, o(0, 0, 0, 0, 0, 0, 1), "b_kill2");
        step(1, add6, o(0, 0, 0, 0, 0, 0, 1), "b_kill3");
        step(1, add6, o(0, 0, 0, 0, 0, 0, 0), "b_resume");
        step(1, ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), o(0, 0, 1, 6, 1, 0, 0), "b_redir_invalid");
        step(1, idle, o(0, 0, 0, 0, 0, 0, 0), "b_no_flush");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
